// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch stage.
// Counter widths are derived from the queue depth.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_stage_fetch_queue.sv
// Synchronous FIFO with flush; holds fetched entries or in-flight PC tags.
// Flush wins over push and pop issued in the same cycle.
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with a credit-limited prefetch queue.
// Branches flush the queue; in-flight responses are counted off and dropped.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              freeze,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
);

  localparam int            CW    = cnt_w(DEPTH);
  localparam int            EW    = ADDR_W + DATA_W;
  localparam logic [CW+1:0] LIMIT = (CW+2)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     tag_cnt;
  logic [CW+1:0]     used;
  logic [EW-1:0]     q_rdata;
  logic              q_full;
  logic              q_empty;
  logic              tag_full;
  logic              tag_empty;
  logic              fire;
  logic              rsp_keep;
  logic              deq;

  assign used = (CW+2)'(occ) + (CW+2)'(outstanding)
              + (CW+2)'(drop_cnt);

  // Credits cover every in-flight response, so the queue never overflows.
  assign imem_req_valid = ~rst & ~branch_taken & (used < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & (drop_cnt == '0);
  assign deq            = if_valid & ~freeze;

  assign if_valid = ~q_empty;
  assign if_pc    = q_empty ? '0 : q_rdata[EW-1:DATA_W];
  assign if_instr = q_empty ? DATA_W'(NOP_INSTR)
                            : q_rdata[DATA_W-1:0];

  fetch_queue #(.DEPTH(DEPTH), .W(EW)) u_entry_q (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (rsp_keep),
    .pop   (deq),
    .wdata ({tag_pc, imem_rsp_data}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (occ)
  );

  fetch_queue #(.DEPTH(DEPTH), .W(ADDR_W)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (fire),
    .pop   (rsp_keep),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (branch_taken) begin
      // Any response this cycle is discarded, stale or not.
      fetch_pc    <= branch_addr;
      drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
      outstanding <= '0;
    end else begin
      if (fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      outstanding <= outstanding + CW'(fire) - CW'(rsp_keep);
      drop_cnt    <= drop_cnt
                   - CW'(imem_rsp_valid && drop_cnt != '0);
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (rst)
    used <= LIMIT);
  a_tags: assert property (@(posedge clk) disable iff (rst)
    tag_cnt == outstanding);
  a_tag_avail: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !tag_empty);
  a_tag_room: assert property (@(posedge clk) disable iff (rst)
    fire |-> !tag_full);
  a_q_room: assert property (@(posedge clk) disable iff (rst)
    (rsp_keep && !deq) |-> !q_full);

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. It decouples the PC sequencer from a variable-latency instruction memory through a request/response handshake. It delivers {PC, instruction} pairs to ID with a valid flag and honours the freeze stall. A taken branch flushes the queue and redirects fetch, and responses for requests already in flight are discarded.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_STEP, 4, sequential PC increment in bytes
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
branch_taken  in  1  redirect request from EXE, single-cycle pulse
branch_addr  in  ADDR_W  redirect target
freeze  in  1  ID stall; head entry is held and not consumed
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  fetch address
imem_rsp_valid  in  1  response strobe; in order, at most one per cycle, never back-pressured
imem_rsp_data  in  DATA_W  fetched instruction
if_valid  out  1  queue head is valid
if_pc  out  ADDR_W  PC of head entry (0 when empty)
if_instr  out  DATA_W  head instruction (NOP = 0 when empty)

Behaviour:
- Reset (async, any time, including mid-flush or with requests in flight):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
- Credit rule: imem_req_valid = ~branch_taken && (occupancy + outstanding + drop_cnt < DEPTH).
  - This guarantees every response has a slot, so the queue can never overflow.
- Issue: imem_req_addr=fetch_pc. On valid&&ready, outstanding+1 and fetch_pc += PC_STEP, wrapping modulo 2^ADDR_W.
- Response:
  - If drop_cnt>0: drop_cnt-1 and discard the data.
  - Else: outstanding-1 and push {pc_tag, data}. pc_tag comes from an in-order tag FIFO of issued addresses (DEPTH deep).
- Output: the head entry is registered, visible the cycle after push. Minimum latency is request accepted at cycle t, rsp at t+L, if_valid at t+L+1.
- Pop: when if_valid && ~freeze. The next entry appears the following cycle, giving full throughput of 1/cycle.
- Freeze: if_pc/if_instr/if_valid are held stable. Requests continue until credits are exhausted.
- branch_taken (highest priority):
  - Next cycle: queue empty, if_valid=0, fetch_pc=branch_addr.
  - drop_cnt += outstanding (minus 1 if a non-stale response arrives the same cycle; that response is discarded); outstanding=0.
  - A push or pop in the same cycle is cancelled.
  - The first request to branch_addr is issued no earlier than the cycle after the branch.
- Back-to-back branches: the latest one wins. drop_cnt accumulates so that all stale responses are dropped.
- Counters are $clog2(DEPTH+1) bits wide. Occupancy+outstanding+drop_cnt <= DEPTH is an invariant and is asserted in simulation.
- imem_req_addr/valid are combinational from state only and do not depend on imem_req_ready.

Decomposition:
- Package if_pkg holds:
  - NOP_INSTR constant (0);
  - fetch_entry_t typedef {pc, instr};
  - clog2-based counter width helper.
- Sub-module fetch_queue: synchronous FIFO parametrised by DEPTH and entry width.
  - Provides push, pop, flush, full, empty and count, with pointer wrap modulo DEPTH.
  - It is instantiated twice: the entry queue and the PC tag FIFO.

Test Plan:
- Reset, then rsp latency 1 with ready=1 and freeze=0 -> requests to 0,4,8...; if_valid first at cycle 3; if_pc 0,4,8 on consecutive cycles with matching data.
- Hold freeze=1 with DEPTH=4 -> exactly 4 requests (0..12) issued, then imem_req_valid=0; if_pc stays 0. Release -> 0,4,8,12 drain and requests resume at 16.
- Latency 3 with 2 requests outstanding, then branch_taken to 0x100 -> the next 2 responses are discarded; the first if_valid carries if_pc=0x100; no stale PCs ever appear.
- branch_taken coincident with rsp_valid and a pop -> the response is dropped, the queue is empty next cycle, and the next fetch address is branch_addr.
- imem_req_ready low for 5 cycles -> imem_req_addr is held constant; fetch_pc does not advance; there are no duplicate or missing PCs.
- Branch to 0xFFFFFFF8 -> fetch sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Asserting rst mid-stream -> all outputs 0 immediately, and the first request after release goes to RESET_PC.
